// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: start/stop/clear FSM, tenth-second prescaler and a 4-digit BCD cascade (0:00.0 .. 9:59.9).
// Latency: buttons act on the edge that samples them; digits, running and wrap are registered and update on that same edge.
// Backpressure: none. Buttons are single-cycle pulses; a held button counts as one pulse per cycle.
//
// Ports:
//   clk            - rising-edge clock
//   reset          - asynchronous active-high reset; clears all state
//   btn_start_stop - toggles run/pause (IDLE->RUN, RUN->PAUSE, PAUSE->RUN)
//   btn_clear      - zeroes digits and prescaler and returns to IDLE; beats start/stop
//   d_tenths, d_sec_ones, d_sec_tens, d_min - BCD digits for the display driver
//   running        - high while in RUN
//   wrap           - one-cycle pulse when the count rolls 9:59.9 -> 0:00.0
module stopwatch_ctrl #(
  parameter int TICK_DIV = 10000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  output logic [3:0] d_tenths,
  output logic [3:0] d_sec_ones,
  output logic [3:0] d_sec_tens,
  output logic [3:0] d_min,
  output logic       running,
  output logic       wrap
);

  localparam int            PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_presc;
  logic [PW-1:0] w_presc_nxt;
  logic          w_run;
  logic          w_tick;
  logic [3:0]    r_d_tenths;
  logic [3:0]    r_d_sec_ones;
  logic [3:0]    r_d_sec_tens;
  logic [3:0]    r_d_min;
  logic          r_wrap;
  // {carry_out, sum} of each limited incrementor stage
  logic [4:0]    w_inc_tenths;
  logic [4:0]    w_inc_sec_ones;
  logic [4:0]    w_inc_sec_tens;
  logic [4:0]    w_inc_min;

  // Limited incrementor: a+ci, folding to 0 with a carry when it reaches lim.
  function automatic logic [4:0] lim_inc(input logic [3:0] a, input logic ci, input logic [4:0] lim);
    logic [4:0] s;
    s = {1'b0, a} + {4'b0000, ci};
    if (s >= lim) begin
      return 5'b1_0000;
    end
    return {1'b0, s[3:0]};
  endfunction

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (btn_clear) begin
      // clear wins over a simultaneous start/stop, which is dropped
      w_state_nxt = ST_IDLE;
    end else if (btn_start_stop) begin
      case (r_state)
        ST_IDLE:  w_state_nxt = ST_RUN;
        ST_RUN:   w_state_nxt = ST_PAUSE;
        ST_PAUSE: w_state_nxt = ST_RUN;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // ---------------- prescaler ----------------
  // Counting follows the current state, so the cycle that samples a pause
  // still counts (and may still tick); the partial tenth survives the pause.
  assign w_run  = (r_state == ST_RUN);
  assign w_tick = w_run && (r_presc == PRESC_LAST) && !btn_clear;

  always_comb begin
    w_presc_nxt = r_presc;
    if (btn_clear) begin
      w_presc_nxt = '0;
    end else if (w_run) begin
      w_presc_nxt = w_tick ? '0 : (r_presc + PW'(1));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
    end else begin
      r_presc <= w_presc_nxt;
    end
  end

  // ---------------- digit cascade ----------------
  // Whole carry chain settles in one cycle; all digits load on the same edge.
  assign w_inc_tenths   = lim_inc(r_d_tenths,   w_tick,            5'd10);
  assign w_inc_sec_ones = lim_inc(r_d_sec_ones, w_inc_tenths[4],   5'd10);
  assign w_inc_sec_tens = lim_inc(r_d_sec_tens, w_inc_sec_ones[4], 5'd6);
  assign w_inc_min      = lim_inc(r_d_min,      w_inc_sec_tens[4], 5'd10);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_d_tenths   <= 4'd0;
      r_d_sec_ones <= 4'd0;
      r_d_sec_tens <= 4'd0;
      r_d_min      <= 4'd0;
      r_wrap       <= 1'b0;
    end else if (btn_clear) begin
      r_d_tenths   <= 4'd0;
      r_d_sec_ones <= 4'd0;
      r_d_sec_tens <= 4'd0;
      r_d_min      <= 4'd0;
      r_wrap       <= 1'b0;
    end else begin
      r_d_tenths   <= w_inc_tenths[3:0];
      r_d_sec_ones <= w_inc_sec_ones[3:0];
      r_d_sec_tens <= w_inc_sec_tens[3:0];
      r_d_min      <= w_inc_min[3:0];
      // minutes carry only happens on a tick from 9:59.9, so it marks the rollover
      r_wrap       <= w_inc_min[4];
    end
  end

  assign d_tenths   = r_d_tenths;
  assign d_sec_ones = r_d_sec_ones;
  assign d_sec_tens = r_d_sec_tens;
  assign d_min      = r_d_min;
  assign running    = w_run;
  assign wrap       = r_wrap;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with TICK_DIV=4: directed scenarios plus random button traffic,
// compared every cycle against a model that keeps the elapsed time as a single tenths count.
// Inputs driven on the falling edge, outputs sampled on the falling edge after each rising edge.
module tb_stopwatch_ctrl;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_ss = 1'b0;
  logic       btn_clr = 1'b0;
  logic [3:0] d_tenths, d_sec_ones, d_sec_tens, d_min;
  logic       running, wrap;

  stopwatch_ctrl #(.TICK_DIV(TD)) dut (
    .clk            (clk),
    .reset          (reset),
    .btn_start_stop (btn_ss),
    .btn_clear      (btn_clr),
    .d_tenths       (d_tenths),
    .d_sec_ones     (d_sec_ones),
    .d_sec_tens     (d_sec_tens),
    .d_min          (d_min),
    .running        (running),
    .wrap           (wrap)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: mode 0=idle 1=run 2=pause, elapsed time in tenths (0..5999), cycles into the current tenth.
  int m_mode  = 0;
  int m_cnt   = 0;
  int m_phase = 0;
  bit m_wrap  = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic int dig_of(input int c);
    return ((c / 600) << 12) | (((c / 100) % 6) << 8) | (((c / 10) % 10) << 4) | (c % 10);
  endfunction

  function automatic int dut_dig();
    return {16'h0000, d_min, d_sec_tens, d_sec_ones, d_tenths};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_phase = 0; m_wrap = 1'b0;
  endtask

  task automatic model_edge(input bit ss, input bit clr);
    if (clr) begin
      model_reset();
    end else begin
      m_wrap = 1'b0;
      if (m_mode == 1) begin
        m_phase++;
        if (m_phase == TD) begin
          m_phase = 0;
          m_cnt   = (m_cnt + 1) % 6000;
          m_wrap  = (m_cnt == 0);
        end
      end
      if (ss) m_mode = (m_mode == 1) ? 2 : 1;
    end
  endtask

  task automatic step(input bit ss, input bit clr);
    btn_ss  = ss;
    btn_clr = clr;
    @(posedge clk);
    model_edge(ss, clr);
    @(negedge clk);
    chk("digits", dut_dig(), dig_of(m_cnt));
    chk("running", int'(running), int'(m_mode == 1));
    chk("wrap", int'(wrap), int'(m_wrap));
    btn_ss  = 1'b0;
    btn_clr = 1'b0;
  endtask

  initial begin
    // power-on reset
    repeat (2) @(negedge clk);
    chk("rst_digits", dut_dig(), 0);
    chk("rst_running", int'(running), 0);
    chk("rst_wrap", int'(wrap), 0);
    reset = 1'b0;
    model_reset();

    // asynchronous reset mid-count, checked before any clock edge
    step(1'b1, 1'b0);
    repeat (9) step(1'b0, 1'b0);
    chk("pre_rst_tenths", int'(d_tenths), 2);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_digits", dut_dig(), 0);
    chk("async_rst_running", int'(running), 0);
    chk("async_rst_wrap", int'(wrap), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) step(1'b0, 1'b0);

    // start and run 40 cycles -> 0:01.0
    step(1'b1, 1'b0);
    repeat (40) step(1'b0, 1'b0);
    chk("start_digits", dut_dig(), 'h0010);
    chk("start_running", int'(running), 1);

    // pause after 6 cycles, hold, resume
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("pause_running", int'(running), 0);
    repeat (20) step(1'b0, 1'b0);
    chk("pause_hold", dut_dig(), 'h0001);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("resume_1cyc", int'(d_tenths), 1);
    step(1'b0, 1'b0);
    chk("resume_2cyc", int'(d_tenths), 2);

    // cascade 0:59.9 -> 1:00.0 and wrap 9:59.9 -> 0:00.0
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    for (int i = 0; i < 5000 && m_cnt != 599; i++) step(1'b0, 1'b0);
    chk("at_0599", dut_dig(), 'h0599);
    for (int i = 0; i < TD; i++) begin
      step(1'b0, 1'b0);
      if (d_min == 4'd1) break;
    end
    chk("carry_1000", dut_dig(), 'h1000);
    for (int i = 0; i < 30000 && m_cnt != 5999; i++) step(1'b0, 1'b0);
    chk("at_9599", dut_dig(), 'h9599);
    for (int i = 0; i < TD; i++) begin
      step(1'b0, 1'b0);
      if (wrap) break;
    end
    chk("wrap_high", int'(wrap), 1);
    chk("wrap_digits", dut_dig(), 0);
    chk("wrap_running", int'(running), 1);
    step(1'b0, 1'b0);
    chk("wrap_one_cycle", int'(wrap), 0);

    // clear on a tick edge, then clear mid-tenth
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    repeat (7) step(1'b0, 1'b0);
    chk("pre_clear_tenths", int'(d_tenths), 1);
    step(1'b0, 1'b1);
    chk("clr_tick_digits", dut_dig(), 0);
    chk("clr_tick_running", int'(running), 0);
    chk("clr_tick_wrap", int'(wrap), 0);
    step(1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("clr_mid_digits", dut_dig(), 0);
    repeat (5) step(1'b0, 1'b0);

    // simultaneous start+clear from PAUSE
    step(1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("sim_paused", int'(running), 0);
    step(1'b1, 1'b1);
    chk("sim_running", int'(running), 0);
    chk("sim_digits", dut_dig(), 0);
    repeat (3) step(1'b0, 1'b0);
    chk("sim_idle_hold", int'(running), 0);
    step(1'b1, 1'b0);
    chk("sim_restart", int'(running), 1);

    // random button traffic, including overlapping presses
    repeat (3000) step($urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
